reg_file: RTL and testbench

- MIPS general-purpose register file. Sits directly upstream of the ALU.
- Read port 1 drives the ALU srca operand. Read port 2 drives the srcb mux and store data.
- The single write port is fed by the writeback path, which carries the ALU result or load data.
- 32 entries; register $0 is hardwired to zero.

---
 rtl/reg_file.sv | 86 ++++++++
 tb/tb_reg_file.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// reg_file: MIPS general-purpose register file.
// Two combinational read ports (rs -> ALU srca, rt -> srcb/store data) and one
// synchronous write port fed by writeback. Register $0 always reads zero.
// wr_count counts committed writes (wraps at 16 bits) for debug/perf.
// Optional feature macro: REGFILE_BYPASS_EN -- write-through bypass so a read
// of the index being written in the same cycle returns wd3 instead of the old
// value. Without it, same-cycle reads return the old contents.
// reset is synchronous, active-high, and has priority over we3.

module reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] a1,
    input  logic [ADDR_W-1:0] a2,
    input  logic [ADDR_W-1:0] a3,
    input  logic              we3,
    input  logic [DATA_W-1:0] wd3,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [15:0]       wr_count
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              commit;

    // A write commits only outside reset and never to $0.
    assign commit = we3 && !reset && (a3 != '0);

    // Storage update: reset clears every entry, otherwise commit the write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (commit) begin
            mem[a3] <= wd3;
        end
    end

    // Committed-write counter, free-running wrap with no overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_count <= '0;
        end else if (commit) begin
            wr_count <= wr_count + 16'd1;
        end
    end

    // Read port 1: zero during reset and for $0, optional same-cycle bypass.
    always_comb begin
        rd1 = '0;
        if (!reset && (a1 != '0)) begin
`ifdef REGFILE_BYPASS_EN
            if (commit && (a1 == a3)) begin
                rd1 = wd3;
            end else begin
                rd1 = mem[a1];
            end
`else
            rd1 = mem[a1];
`endif
        end
    end

    // Read port 2: same rules as port 1, indexed by a2.
    always_comb begin
        rd2 = '0;
        if (!reset && (a2 != '0)) begin
`ifdef REGFILE_BYPASS_EN
            if (commit && (a2 == a3)) begin
                rd2 = wd3;
            end else begin
                rd2 = mem[a2];
            end
`else
            rd2 = mem[a2];
`endif
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: self-checking bench for reg_file.
// Reference model is a plain array of register values plus an integer write
// count, updated at each rising edge from the inputs applied in that cycle.
// Optional feature macro: REGFILE_BYPASS_EN (expected same-cycle read values).

module tb_reg_file;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] a1, a2, a3;
    logic              we3;
    logic [DATA_W-1:0] wd3;
    logic [DATA_W-1:0] rd1, rd2;
    logic [15:0]       wr_count;

    logic [DATA_W-1:0] model [32];
    int                exp_count;
    int                tests_run;
    int                tests_failed;

    reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .a1       (a1),
        .a2       (a2),
        .a3       (a3),
        .we3      (we3),
        .wd3      (wd3),
        .rd1      (rd1),
        .rd2      (rd2),
        .wr_count (wr_count)
    );

    // Clock: 10 ns period.
    always #5 clk = ~clk;

    // Expected read value for an index given the current inputs.
    function automatic logic [DATA_W-1:0] exp_rd(input logic [ADDR_W-1:0] a);
        if (reset) return '0;
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we3 && a3 != 0 && a == a3) return wd3;
`endif
        return model[a];
    endfunction

    // Advance one clock edge, applying the architectural rules to the model.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) model[i] = '0;
            exp_count = 0;
        end else if (we3 && a3 != 0) begin
            model[a3] = wd3;
            exp_count = (exp_count + 1) % 65536;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        we3 = 1'b0; a3 = '0; wd3 = '0;
        tick();
        tick();
        a1 = 5'd5; a2 = 5'd31;
        #1;
        tests_run++;
        if (rd1 !== '0 || rd2 !== '0) begin
            tests_failed++;
            $display("FAIL reset_hold_read: rd1=%h rd2=%h expected 0 0", rd1, rd2);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if (rd1 !== 32'h0 || rd2 !== 32'h0 || wr_count !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_state: rd1=%h rd2=%h wr_count=%h expected 0 0 0",
                     rd1, rd2, wr_count);
        end
    endtask

    task automatic test_basic_write();
        we3 = 1'b1; a3 = 5'd8; wd3 = 32'h0000_0010;
        tick();
        a3 = 5'd9; wd3 = 32'h0000_0020;
        tick();
        we3 = 1'b0; a1 = 5'd8; a2 = 5'd9;
        #1;
        tests_run++;
        if (rd1 !== 32'd16 || rd2 !== 32'd32 || wr_count !== 16'd2) begin
            tests_failed++;
            $display("FAIL basic_write: rd1=%0d rd2=%0d wr_count=%0d expected 16 32 2",
                     rd1, rd2, wr_count);
        end
    endtask

    task automatic test_write_zero();
        we3 = 1'b1; a3 = 5'd0; wd3 = 32'hDEAD_BEEF; a1 = 5'd0; a2 = 5'd0;
        #1;
        tests_run++;
        if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
            tests_failed++;
            $display("FAIL write_zero_same_cycle: rd1=%h rd2=%h expected 0 0", rd1, rd2);
        end
        tick();
        we3 = 1'b0;
        #1;
        tests_run++;
        if (rd1 !== 32'h0 || wr_count !== 16'd2) begin
            tests_failed++;
            $display("FAIL write_zero_after: rd1=%h wr_count=%0d expected 0 2", rd1, wr_count);
        end
    endtask

    task automatic test_read_during_write();
        logic [DATA_W-1:0] exp_before;
`ifdef REGFILE_BYPASS_EN
        exp_before = 32'h1234_5678;
`else
        exp_before = 32'd16;
`endif
        we3 = 1'b1; a3 = 5'd8; wd3 = 32'h1234_5678; a1 = 5'd8; a2 = 5'd9;
        #1;
        tests_run++;
        if (rd1 !== exp_before || rd2 !== 32'd32) begin
            tests_failed++;
            $display("FAIL rdw_before_edge: rd1=%h rd2=%h expected %h 00000020",
                     rd1, rd2, exp_before);
        end
        tick();
        we3 = 1'b0;
        #1;
        tests_run++;
        if (rd1 !== 32'h1234_5678 || wr_count !== 16'd3) begin
            tests_failed++;
            $display("FAIL rdw_after_edge: rd1=%h wr_count=%0d expected 12345678 3",
                     rd1, wr_count);
        end
    endtask

    task automatic test_reset_with_write();
        reset = 1'b1; we3 = 1'b1; a3 = 5'd10; wd3 = 32'd7; a1 = 5'd8; a2 = 5'd10;
        #1;
        tests_run++;
        if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_forces_zero: rd1=%h rd2=%h expected 0 0", rd1, rd2);
        end
        tick();
        reset = 1'b0; we3 = 1'b0; a1 = 5'd10; a2 = 5'd8;
        #1;
        tests_run++;
        if (rd1 !== 32'h0 || rd2 !== 32'h0 || wr_count !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_with_write: rd1=%h rd2=%h wr_count=%0d expected 0 0 0",
                     rd1, rd2, wr_count);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 39) == 0);
            we3   = ($urandom_range(0, 3) != 0);
            a1    = ADDR_W'($urandom_range(0, 31));
            a2    = ($urandom_range(0, 7) == 0) ? a1 : ADDR_W'($urandom_range(0, 31));
            a3    = ($urandom_range(0, 3) == 0) ? a1 : ADDR_W'($urandom_range(0, 31));
            wd3   = $urandom;
            #1;
            tests_run++;
            if (rd1 !== exp_rd(a1) || rd2 !== exp_rd(a2) || wr_count !== exp_count[15:0]) begin
                tests_failed++;
                $display("FAIL random[%0d]: rd1=%h rd2=%h wr_count=%h expected %h %h %h",
                         n, rd1, rd2, wr_count, exp_rd(a1), exp_rd(a2), exp_count[15:0]);
            end
            tick();
        end
        reset = 1'b0; we3 = 1'b0;
    endtask

    task automatic test_wrap();
        logic [DATA_W-1:0] last;
        reset = 1'b1; we3 = 1'b0;
        tick();
        reset = 1'b0; we3 = 1'b1; a3 = 5'd1;
        for (int n = 0; n < 65535; n++) begin
            wd3 = $urandom;
            tick();
        end
        we3 = 1'b0;
        #1;
        tests_run++;
        if (wr_count !== 16'hFFFF || wr_count !== exp_count[15:0]) begin
            tests_failed++;
            $display("FAIL wrap_preload: wr_count=%h expected ffff", wr_count);
        end
        we3 = 1'b1; wd3 = $urandom; last = wd3;
        tick();
        we3 = 1'b0; a1 = 5'd1;
        #1;
        tests_run++;
        if (wr_count !== 16'h0000 || rd1 !== last) begin
            tests_failed++;
            $display("FAIL wrap_rollover: wr_count=%h rd1=%h expected 0000 %h",
                     wr_count, rd1, last);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        exp_count = 0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        reset = 1'b1; we3 = 1'b0; a1 = '0; a2 = '0; a3 = '0; wd3 = '0;
        test_reset();
        test_basic_write();
        test_write_zero();
        test_read_during_write();
        test_reset_with_write();
        test_random();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
